// File: rtl/shadow_write_queue.sv
// Shadow-write queue: buffers filtered Apple II bus writes as byte-lane SDRAM word writes. Optional SHADOW_COALESCE_EN merges writes into the newest entry.
// Latency: a write accepted in cycle N is presented on mem_wr_o in cycle N+1 (first-word-fall-through).
// Backpressure: the head holds until mem_ready_i; pushes while full are dropped and counted (overflow_o, drop_count_o).
module shadow_write_queue #(
    parameter int   DEPTH             = 8,
    parameter int   BANK_BITS         = 1,
    parameter int   ADDR_WIDTH        = 21,
    parameter logic SHADOW_ALL_MEMORY = 1'b0
) (
    input  logic                   clk_logic,
    input  logic                   system_reset_n,
    input  logic                   bus_wr_i,
    input  logic [15:0]            bus_addr_i,
    input  logic [BANK_BITS-1:0]   bus_bank_i,
    input  logic [7:0]             bus_data_i,
    output logic                   mem_wr_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [31:0]            mem_data_o,
    output logic [3:0]             mem_byte_en_o,
    input  logic                   mem_ready_i,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   overflow_o,
    output logic [7:0]             drop_count_o,
    input  logic                   status_clr_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           dat;
        logic [3:0]            be;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         fill;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            lane;
    entry_t                new_ent;
    logic                  in_window;
    logic                  accept;
    logic                  pop;
    logic                  full;
    logic                  merge;
    logic                  push;
    logic                  drop;
    logic                  wr_en;

    // Upper bank bits extend the word address above the 15-bit in-bank word index.
    generate
        if (BANK_BITS > 1) begin : g_bank
            always_comb begin
                word_addr                      = '0;
                word_addr[14:0]                = bus_addr_i[15:1];
                word_addr[15 +: BANK_BITS-1]   = bus_bank_i[BANK_BITS-1:1];
            end
        end else begin : g_nobank
            always_comb begin
                word_addr       = '0;
                word_addr[14:0] = bus_addr_i[15:1];
            end
        end
    endgenerate

    assign lane      = {bus_addr_i[0], bus_bank_i[0]};
    assign in_window = SHADOW_ALL_MEMORY
                    || ((bus_addr_i >= 16'h0400) && (bus_addr_i <= 16'h0BFF))
                    || ((bus_addr_i >= 16'h2000) && (bus_addr_i <= 16'h5FFF));

    always_comb begin
        new_ent      = '0;
        new_ent.addr = word_addr;
        new_ent.dat  = {4{bus_data_i}};
        new_ent.be   = 4'b0001 << lane;
    end

    assign accept = bus_wr_i && in_window;
    assign pop    = (fill != '0) && mem_ready_i;
    assign full   = (fill == FULL_CNT);

`ifdef SHADOW_COALESCE_EN
    logic [PW-1:0] last_ptr;
    assign last_ptr = wr_ptr - PW'(1);
    // A lone entry being popped this cycle cannot absorb the write; it pushes instead.
    assign merge = accept && (fill != '0) && (mem[last_ptr].addr == word_addr)
                && !(pop && (fill == CW'(1)));
`else
    assign merge = 1'b0;
`endif

    assign push  = accept && !merge;
    assign drop  = push && full && !pop;
    assign wr_en = push && !drop;

    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fill         <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= 8'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase
            // A clear coinciding with a drop leaves exactly that one drop recorded.
            if (status_clr_i) begin
                overflow_o   <= drop;
                drop_count_o <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (wr_en) mem[wr_ptr] <= new_ent;
`ifdef SHADOW_COALESCE_EN
        if (merge) begin
            mem[last_ptr].be                     <= mem[last_ptr].be | new_ent.be;
            mem[last_ptr].dat[{lane, 3'b000} +: 8] <= bus_data_i;
        end
`endif
    end

    assign mem_wr_o      = (fill != '0);
    assign mem_addr_o    = mem[rd_ptr].addr;
    assign mem_data_o    = mem[rd_ptr].dat;
    assign mem_byte_en_o = mem[rd_ptr].be;
    assign fill_o        = fill;

endmodule

// File: tb/tb_shadow_write_queue.sv
// Randomized and directed bench for shadow_write_queue against a queue-based reference model.
module tb_shadow_write_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 21;

    logic          clk_logic = 1'b0;
    logic          system_reset_n;
    logic          bus_wr_i;
    logic [15:0]   bus_addr_i;
    logic [0:0]    bus_bank_i;
    logic [7:0]    bus_data_i;
    logic          mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [3:0]    mem_byte_en_o;
    logic          mem_ready_i;
    logic [3:0]    fill_o;
    logic          overflow_o;
    logic [7:0]    drop_count_o;
    logic          status_clr_i;

    shadow_write_queue #(
        .DEPTH(DEPTH), .BANK_BITS(1), .ADDR_WIDTH(AW), .SHADOW_ALL_MEMORY(1'b0)
    ) dut (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n),
        .bus_wr_i(bus_wr_i), .bus_addr_i(bus_addr_i), .bus_bank_i(bus_bank_i),
        .bus_data_i(bus_data_i), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_byte_en_o(mem_byte_en_o), .mem_ready_i(mem_ready_i),
        .fill_o(fill_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o),
        .status_clr_i(status_clr_i)
    );

    always #5 clk_logic = ~clk_logic;

    typedef struct {
        int          a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    bit   m_ov;
    int   m_cnt;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'h0400 && a <= 16'h0BFF) || (a >= 16'h2000 && a <= 16'h5FFF);
    endfunction

    // Reference behaviour for one clock edge, applied from the inputs being driven now.
    task automatic model_apply(input logic wr, input logic [15:0] a, input logic [0:0] b,
                               input logic [7:0] d, input logic rdy, input logic clr);
        bit   pop, acc, mrg, drop, full;
        int   lane, wa;
        ent_t e;
        pop  = (q.size() != 0) && rdy;
        acc  = wr && in_win(a);
        lane = int'(a[0]) * 2 + int'(b[0]);
        wa   = (int'(b) / 2) * 32768 + int'(a) / 2;
        mrg  = 1'b0;
`ifdef SHADOW_COALESCE_EN
        if (acc && q.size() != 0 && q[q.size()-1].a == wa && !(pop && q.size() == 1)) mrg = 1'b1;
`endif
        if (mrg) begin
            e = q[q.size()-1];
            e.be = e.be | 4'(1 << lane);
            e.d[lane*8 +: 8] = d;
            q[q.size()-1] = e;
        end
        full = (q.size() == DEPTH);
        drop = acc && !mrg && full && !pop;
        if (pop) void'(q.pop_front());
        if (acc && !mrg && !drop) begin
            e.a  = wa;
            e.d  = {4{d}};
            e.be = 4'(1 << lane);
            q.push_back(e);
        end
        if (clr) begin
            m_ov  = drop;
            m_cnt = drop ? 1 : 0;
        end else if (drop) begin
            m_ov = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic compare_model();
        check("mem_wr", 32'(mem_wr_o), 32'(q.size() != 0));
        check("fill", 32'(fill_o), 32'(q.size()));
        check("overflow", 32'(overflow_o), 32'(m_ov));
        check("drop_count", 32'(drop_count_o), 32'(m_cnt));
        if (q.size() != 0) begin
            check("head_addr", 32'(mem_addr_o), q[0].a);
            check("head_data", mem_data_o, q[0].d);
            check("head_be", 32'(mem_byte_en_o), 32'(q[0].be));
        end
    endtask

    task automatic step(input logic wr, input logic [15:0] a, input logic [0:0] b,
                        input logic [7:0] d, input logic rdy, input logic clr);
        bus_wr_i     = wr;
        bus_addr_i   = a;
        bus_bank_i   = b;
        bus_data_i   = d;
        mem_ready_i  = rdy;
        status_clr_i = clr;
        model_apply(wr, a, b, d, rdy, clr);
        @(posedge clk_logic);
        @(negedge clk_logic);
        compare_model();
    endtask

    task automatic do_reset();
        system_reset_n = 1'b0;
        bus_wr_i       = 1'b0;
        mem_ready_i    = 1'b0;
        status_clr_i   = 1'b0;
        @(posedge clk_logic);
        @(negedge clk_logic);
        q.delete();
        m_ov  = 1'b0;
        m_cnt = 0;
        check("rst_mem_wr", 32'(mem_wr_o), 32'd0);
        check("rst_fill", 32'(fill_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_drop_count", 32'(drop_count_o), 32'd0);
        system_reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ra, last_a;
        int          r, bias;
        bus_addr_i = '0; bus_bank_i = '0; bus_data_i = '0;
        do_reset();

        // Single write, immediately drained.
        step(1, 16'h2000, 1'b0, 8'hA5, 1, 0);
        check("w1_addr", 32'(mem_addr_o), 32'h1000);
        check("w1_data", mem_data_o, 32'hA5A5A5A5);
        check("w1_be", 32'(mem_byte_en_o), 32'h1);
        step(0, 16'h0, 1'b0, 8'h0, 1, 0);
        check("w1_empty", 32'(fill_o), 32'd0);

        // Nine writes with SDRAM stalled, then push+pop while full, then drain in order.
        for (int i = 0; i < 9; i++) step(1, 16'h0400 + 16'(2 * i), 1'b0, 8'(i), 0, 0);
        check("ovf_fill", 32'(fill_o), 32'd8);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_cnt", 32'(drop_count_o), 32'd1);
        step(1, 16'h0500, 1'b0, 8'h55, 1, 0);
        check("pp_fill", 32'(fill_o), 32'd8);
        check("pp_cnt", 32'(drop_count_o), 32'd1);
        for (int i = 1; i < 9; i++) begin
            int exp_a;
            exp_a = (i < 8) ? 32'h200 + i : 32'h280;
            check("drain_addr", 32'(mem_addr_o), 32'(exp_a));
            step(0, 16'h0, 1'b0, 8'h0, 1, 0);
        end
        check("drain_empty", 32'(fill_o), 32'd0);

        // Address filter and byte-lane selection.
        do_reset();
        step(1, 16'h3001, 1'b1, 8'h3C, 0, 0);
        step(1, 16'hC000, 1'b0, 8'h11, 0, 0);
        check("filt_fill", 32'(fill_o), 32'd1);
        check("filt_be", 32'(mem_byte_en_o), 32'h8);
        check("filt_addr", 32'(mem_addr_o), 32'h1800);

        // Same-word writes: coalesce or separate pushes depending on build.
        do_reset();
        step(1, 16'h2000, 1'b0, 8'h12, 0, 0);
        step(1, 16'h2001, 1'b1, 8'h34, 0, 0);
`ifdef SHADOW_COALESCE_EN
        check("coal_fill", 32'(fill_o), 32'd1);
        check("coal_be", 32'(mem_byte_en_o), 32'h9);
`else
        check("coal_fill", 32'(fill_o), 32'd2);
        check("coal_be", 32'(mem_byte_en_o), 32'h1);
`endif

        // Reset with a stalled head and queued entries.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 16'h4000 + 16'(2 * i), 1'b0, 8'(i), 0, 0);
        check("pre_rst_fill", 32'(fill_o), 32'd5);
        do_reset();

        // Drop counter saturation and clear interactions.
        for (int i = 0; i < 270; i++) step(1, 16'h2000 + 16'(2 * i), 1'b0, 8'(i), 0, 0);
        check("sat_cnt", 32'(drop_count_o), 32'd255);
        step(1, 16'h5000, 1'b0, 8'h77, 0, 1);
        check("clr_drop_ov", 32'(overflow_o), 32'd1);
        check("clr_drop_cnt", 32'(drop_count_o), 32'd1);
        step(0, 16'h0, 1'b0, 8'h0, 0, 1);
        check("clr_ov", 32'(overflow_o), 32'd0);
        check("clr_cnt", 32'(drop_count_o), 32'd0);

        // Randomized traffic with varying SDRAM availability.
        do_reset();
        last_a = 16'h2000;
        bias   = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) bias = $urandom_range(10, 95);
            r = $urandom_range(0, 9);
            if (r < 3)      ra = last_a ^ 16'($urandom_range(0, 1));
            else if (r < 6) ra = 16'($urandom_range(16'h0400, 16'h0BFF));
            else if (r < 9) ra = 16'($urandom_range(16'h2000, 16'h5FFF));
            else            ra = 16'($urandom);
            last_a = ra;
            step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shadow_write_queue.md
SHADOW_WRITE_QUEUE -- requirements
Module: shadow_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue entries; power of two, 2..64.
REQ-002 SHALL have parameter BANK_BITS, default 1: bus bank-select width; 1 = main/aux, 2 = adds IIgs E0/E1 pair.
REQ-003 SHALL have parameter ADDR_WIDTH, default 21: SDRAM word-address width, at least 15+BANK_BITS-1.
REQ-004 SHALL have parameter SHADOW_ALL_MEMORY, default 1'b0: 1 = accept all addresses; 0 = accept $0400-$0BFF and $2000-$5FFF only.
REQ-005 SHALL have port clk_logic, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port system_reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port bus_wr_i, input, 1: one-cycle Apple II bus write strobe.
REQ-008 SHALL have port bus_addr_i, input, 16: bus address, sampled with bus_wr_i.
REQ-009 SHALL have port bus_bank_i, input, BANK_BITS: bank select; bit 0 = aux/E1.
REQ-010 SHALL have port bus_data_i, input, 8: write data.
REQ-011 SHALL have port mem_wr_o, output, 1: SDRAM write request.
REQ-012 SHALL have port mem_addr_o, output, ADDR_WIDTH: SDRAM word address.
REQ-013 SHALL have port mem_data_o, output, 32: write data.
REQ-014 SHALL have port mem_byte_en_o, output, 4: byte lanes.
REQ-015 SHALL have port mem_ready_i, input, 1: SDRAM accepts the entry in any cycle where mem_wr_o and mem_ready_i are both high.
REQ-016 SHALL have port fill_o, output, $clog2(DEPTH)+1: occupied entries.
REQ-017 SHALL have port overflow_o, output, 1: sticky, set when a write is dropped.
REQ-018 SHALL have port drop_count_o, output, 8: dropped writes, saturating at 255.
REQ-019 SHALL have port status_clr_i, input, 1: clears overflow_o and drop_count_o.

Function
REQ-020 A write SHALL be accepted when bus_wr_i is high and the address passes the REQ-004 filter; otherwise it is ignored, with no count or flag change.
REQ-021 An entry SHALL hold address = zero-extended {bus_bank_i[BANK_BITS-1:1], bus_addr_i[15:1]}; with BANK_BITS=1 this is bus_addr_i[15:1].
REQ-022 An entry SHALL hold data = bus_data_i replicated 4 times.
REQ-023 An entry SHALL hold byte_en = 1 << {bus_addr_i[0], bus_bank_i[0]}.
REQ-024 The queue SHALL be first-word-fall-through: mem_wr_o = (fill_o != 0), and mem_addr_o, mem_data_o and mem_byte_en_o present the oldest entry.
REQ-025 Latency: a write accepted in cycle N into an empty queue SHALL drive mem_wr_o high in cycle N+1.
REQ-026 The head entry SHALL stay stable until accepted; it pops on the edge where mem_wr_o and mem_ready_i are both high.
REQ-027 Push and pop in the same cycle SHALL leave fill_o unchanged, including when the queue is full.
REQ-028 Full SHALL mean fill_o == DEPTH; a push while full without a same-cycle pop SHALL be dropped.
REQ-029 A dropped write SHALL set overflow_o and increment drop_count_o, saturating at 255.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 status_clr_i SHALL clear overflow_o and drop_count_o; if it coincides with a drop, the result is overflow_o=1 and drop_count_o=1.
REQ-032 The queue SHALL keep no state machine beyond the pointers, fill count, status registers and, when enabled, the coalesce path.

Reset
REQ-033 While system_reset_n is low at a clock edge, the block SHALL clear pointers, fill_o, overflow_o and drop_count_o, and drive mem_wr_o low.
REQ-034 Reset SHALL discard queued entries, including an unaccepted head; mem_wr_o is low the cycle after reset is sampled.
REQ-035 Entry storage SHALL need no reset; mem_addr_o, mem_data_o and mem_byte_en_o are don't-care while mem_wr_o is low.

Configuration
REQ-036 With macro SHADOW_COALESCE_EN defined, an accepted write whose word address equals the newest entry SHALL merge into that entry instead of pushing.
REQ-037 A merge SHALL OR the byte enables, overwrite the data lane selected by the new write, and leave fill_o unchanged.
REQ-038 A merge SHALL NOT occur into an entry being popped in the same cycle; that write pushes normally.
REQ-039 A merge SHALL succeed while the queue is full and SHALL NOT count as a drop.
REQ-040 Without SHADOW_COALESCE_EN, every accepted write SHALL push one entry.

Verification
REQ-041 Write $2000=$A5, bank 0, mem_ready_i=1 -> next cycle mem_wr_o=1, addr=$1000, data=$A5A5A5A5, byte_en=4'b0001; then fill_o=0.
REQ-042 With mem_ready_i=0 and DEPTH=8, nine writes to distinct filtered addresses -> fill_o=8, overflow_o=1, drop_count_o=1; releasing ready drains 8 entries in order.
REQ-043 Write $3001 with bank=1 and SHADOW_ALL_MEMORY=0; also write $C000 -> only $3001 is queued, with byte_en=4'b1000; $C000 is ignored.
REQ-044 Full queue with push and pop in the same cycle -> fill_o stays 8, drop_count_o unchanged.
REQ-045 With SHADOW_COALESCE_EN, ready=0: write $2000 bank 0, then $2001 bank 1 -> fill_o=1, byte_en=4'b1001; without the macro, fill_o=2.
REQ-046 Assert reset with 5 entries queued and the head stalled -> next cycle mem_wr_o=0, fill_o=0, overflow_o=0.
